// File: rtl/wb_pkg.sv
// Shared widths, select codes and priority-state encoding for the WriteBack port arbiter.
package wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RG_W   = 4;
    localparam int DEF_DOB_W  = 8;

    localparam logic SEL_MEM = 1'b0;
    localparam logic SEL_ALU = 1'b1;

    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } pri_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small {rg, result} FIFO that holds ALU results which lost the write port.
// Push and pop may happen together while full; the popped slot is reused by the push.
module wb_skid_fifo #(
    parameter int DEPTH  = 2,
    parameter int RG_W   = 4,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [RG_W-1:0]   push_rg_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [RG_W-1:0]   head_rg_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o
);

    logic [DEPTH-1:0][RG_W-1:0]   rg_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [AW:0]                  cnt_q;
    logic                         do_push, do_pop;

    assign full_o      = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign level_o     = cnt_q;
    assign head_rg_o   = rg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rg_q     <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                rg_q[wr_ptr_q]   <= push_rg_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the load path and the ALU path.
// Optional starvation guard: define WB_STARVE_GUARD_EN to let a starved ALU head force one win.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RG_W       = DEF_RG_W,
    parameter int DOB_W      = DEF_DOB_W,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_DEFER  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [RG_W-1:0]             alu_rg,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [RG_W-1:0]             mem_rg,
    input  logic [DATA_W-1:0]           mem_do,
    input  logic [DOB_W-1:0]            mem_dob,
    output logic                        wb_we,
    output logic [RG_W-1:0]             wb_rg,
    output logic                        wb_sel_dat,
    output logic [DATA_W-1:0]           wb_do,
    output logic [DATA_W-1:0]           wb_alu,
    output logic [DOB_W-1:0]            wb_dob,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_port_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (MAX_DEFER < 1) begin : g_bad_defer
        $error("wb_port_arbiter: MAX_DEFER must be >= 1");
    end

    logic              fifo_full, fifo_empty;
    logic [RG_W-1:0]   head_rg;
    logic [DATA_W-1:0] head_res;
    logic              src_valid, mem_xfer, alu_win, pop, push, bypass_win;
    logic [RG_W-1:0]   src_rg;
    logic [DATA_W-1:0] src_res;
    pri_state_e        state;

    logic              wb_we_q, wb_sel_q;
    logic [RG_W-1:0]   wb_rg_q;
    logic [DATA_W-1:0] wb_do_q, wb_alu_q;
    logic [DOB_W-1:0]  wb_dob_q;

    // The FIFO head always goes before the live input so results stay in issue order.
    assign src_valid = !fifo_empty || alu_valid;
    assign src_rg    = fifo_empty ? alu_rg : head_rg;
    assign src_res   = fifo_empty ? alu_result : head_res;

    assign mem_ready  = rst_n && ((state != PRI_ALU) || !src_valid);
    assign mem_xfer   = mem_valid && mem_ready;
    assign alu_win    = src_valid && !mem_xfer;
    assign pop        = alu_win && !fifo_empty;
    assign bypass_win = alu_win && fifo_empty;

    assign alu_ready = rst_n && (!fifo_full || pop || (fifo_empty && !mem_xfer));
    assign push      = alu_valid && alu_ready && !bypass_win;

    wb_skid_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .RG_W   (RG_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_rg_i   (alu_rg),
        .push_data_i (alu_result),
        .pop_i       (pop),
        .head_rg_o   (head_rg),
        .head_data_o (head_res),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int                 DEFER_W   = $clog2(MAX_DEFER + 1);
    localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);

    pri_state_e         state_q;
    logic [DEFER_W-1:0] defer_q, defer_d;

    always_comb begin
        defer_d = defer_q;
        if (alu_win) begin
            defer_d = '0;
        end else if (src_valid && defer_q != DEFER_MAX) begin
            defer_d = defer_q + 1'b1;
        end
    end

    // Flip to ALU priority as the losing streak reaches the limit, so the next cycle is forced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI_MEM;
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
            case (state_q)
                PRI_MEM: if (src_valid && !alu_win && defer_d == DEFER_MAX) state_q <= PRI_ALU;
                default: state_q <= PRI_MEM;
            endcase
        end
    end

    assign state = state_q;
`else
    assign state = PRI_MEM;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q  <= 1'b0;
            wb_sel_q <= SEL_MEM;
            wb_rg_q  <= '0;
            wb_do_q  <= '0;
            wb_alu_q <= '0;
            wb_dob_q <= '0;
        end else begin
            wb_we_q <= mem_xfer || alu_win;
            if (mem_xfer) begin
                wb_rg_q  <= mem_rg;
                wb_sel_q <= SEL_MEM;
                wb_do_q  <= mem_do;
                wb_dob_q <= mem_dob;
            end else if (alu_win) begin
                wb_rg_q  <= src_rg;
                wb_sel_q <= SEL_ALU;
                wb_alu_q <= src_res;
            end
        end
    end

    assign wb_we      = wb_we_q;
    assign wb_rg      = wb_rg_q;
    assign wb_sel_dat = wb_sel_q;
    assign wb_do      = wb_do_q;
    assign wb_alu     = wb_alu_q;
    assign wb_dob     = wb_dob_q;

endmodule
